// File: rtl/chain_score_sched.sv
// rtl/chain_score_sched.sv - chaining-score scheduler: predecessor issue, score merge, anchor ring history
// Define CHAIN_BACKTRACK_EN to track the best predecessor distance and drive it on out_pred.
module chain_score_sched #(
  parameter int MAX_PRED  = 16,
  parameter int SCORE_LAT = 8,
  parameter int PW        = $clog2(MAX_PRED) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_first,
  input  logic [31:0]   in_rx,
  input  logic [31:0]   in_qx,
  input  logic [31:0]   in_w,
  input  logic [31:0]   cfg_w_avg,
  output logic [31:0]   sc_rx,
  output logic [31:0]   sc_ry,
  output logic [31:0]   sc_qx,
  output logic [31:0]   sc_qy,
  output logic [31:0]   sc_w,
  output logic [31:0]   sc_w_avg,
  output logic          sc_valid,
  input  logic [31:0]   sc_result,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_f,
  output logic [PW-1:0] out_pred
);

  localparam int AW = $clog2(MAX_PRED);
  localparam logic [SCORE_LAT-1:0] EXIT_MASK = SCORE_LAT'(1) << (SCORE_LAT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUT} state_t;
  state_t state_q;

  logic [31:0]          ring_rx [MAX_PRED];
  logic [31:0]          ring_qx [MAX_PRED];
  logic [31:0]          ring_f  [MAX_PRED];
  logic [AW-1:0]        wptr_q;
  logic [PW-1:0]        cnt_q, k_q, j_q;
  logic [31:0]          rx_q, qx_q, w_q, w_avg_q, best_q, ry_q, qy_q;
  logic                 sc_valid_q, out_valid_q;
  logic [SCORE_LAT-1:0] tag_v_q, tag_live_q;
`ifdef CHAIN_BACKTRACK_EN
  logic [PW-1:0]        tag_j_q [SCORE_LAT];
  logic [PW-1:0]        pred_q;
`else
  logic [PW-1:0]        ret_cnt_q;
`endif

  logic          accept, live, pending, ret_hit, take;
  logic [PW-1:0] k_d, j_d, ret_j;
  logic [AW-1:0] rd_idx, ret_idx;
  logic [31:0]   f_j, cand;
  logic [32:0]   sum;

  always_comb begin
    accept  = in_valid && in_ready;
    k_d     = in_first ? '0 : cnt_q;
    j_d     = (state_q == ISSUE) ? j_q + PW'(1) : PW'(1);
    rd_idx  = wptr_q - j_d[AW-1:0];
    live    = (ry_q < rx_q) && (qy_q < qx_q);
    // the exit stage is consumed this cycle, so only younger tags keep DRAIN waiting
    pending = |(tag_v_q & ~EXIT_MASK);
`ifdef CHAIN_BACKTRACK_EN
    ret_j   = tag_j_q[SCORE_LAT-1];
`else
    ret_j   = ret_cnt_q;
`endif
    ret_idx = wptr_q - ret_j[AW-1:0];
    f_j     = ring_f[ret_idx];
    sum     = {f_j[31], f_j} + {sc_result[31], sc_result};
    if (sum[32] != sum[31]) cand = sum[32] ? 32'h8000_0000 : 32'h7fff_ffff;
    else                    cand = sum[31:0];
    ret_hit = tag_v_q[SCORE_LAT-1] && tag_live_q[SCORE_LAT-1];
    take    = ret_hit && ($signed(cand) > $signed(best_q));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      wptr_q      <= '0;
      cnt_q       <= '0;
      k_q         <= '0;
      j_q         <= '0;
      rx_q        <= '0;
      qx_q        <= '0;
      w_q         <= '0;
      w_avg_q     <= '0;
      best_q      <= '0;
      ry_q        <= '0;
      qy_q        <= '0;
      sc_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      tag_v_q     <= '0;
      tag_live_q  <= '0;
`ifdef CHAIN_BACKTRACK_EN
      pred_q      <= '0;
      for (int s = 0; s < SCORE_LAT; s++) tag_j_q[s] <= '0;
`else
      ret_cnt_q   <= '0;
`endif
    end else begin
      tag_v_q[0]    <= sc_valid_q;
      tag_live_q[0] <= sc_valid_q && live;
      for (int s = 1; s < SCORE_LAT; s++) begin
        tag_v_q[s]    <= tag_v_q[s-1];
        tag_live_q[s] <= tag_live_q[s-1];
      end
`ifdef CHAIN_BACKTRACK_EN
      tag_j_q[0] <= j_q;
      for (int s = 1; s < SCORE_LAT; s++) tag_j_q[s] <= tag_j_q[s-1];
      if (take) pred_q <= ret_j;
`else
      // returns come back in issue order, so a counter recovers the distance
      if (tag_v_q[SCORE_LAT-1]) ret_cnt_q <= ret_cnt_q + PW'(1);
`endif
      if (take) best_q <= cand;

      case (state_q)
        IDLE: if (accept) begin
          rx_q    <= in_rx;
          qx_q    <= in_qx;
          w_q     <= in_w;
          w_avg_q <= cfg_w_avg;
          best_q  <= in_w;
          cnt_q   <= k_d;
          k_q     <= k_d;
          j_q     <= PW'(1);
`ifdef CHAIN_BACKTRACK_EN
          pred_q  <= '0;
`else
          ret_cnt_q <= PW'(1);
`endif
          if (k_d != '0) begin
            state_q    <= ISSUE;
            sc_valid_q <= 1'b1;
            ry_q       <= ring_rx[rd_idx];
            qy_q       <= ring_qx[rd_idx];
          end else begin
            state_q     <= OUT;
            out_valid_q <= 1'b1;
          end
        end
        ISSUE: if (j_q == k_q) begin
          sc_valid_q <= 1'b0;
          state_q    <= DRAIN;
        end else begin
          j_q  <= j_d;
          ry_q <= ring_rx[rd_idx];
          qy_q <= ring_qx[rd_idx];
        end
        DRAIN: if (!pending) begin
          state_q     <= OUT;
          out_valid_q <= 1'b1;
        end
        OUT: if (out_ready) begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
          wptr_q      <= wptr_q + 1'b1;
          cnt_q       <= (cnt_q == PW'(MAX_PRED)) ? cnt_q : cnt_q + PW'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == OUT && out_ready) begin
      ring_rx[wptr_q] <= rx_q;
      ring_qx[wptr_q] <= qx_q;
      ring_f[wptr_q]  <= best_q;
    end
  end

  assign in_ready  = (state_q == IDLE) && !reset;
  assign sc_valid  = sc_valid_q;
  assign sc_rx     = rx_q;
  assign sc_qx     = qx_q;
  assign sc_ry     = ry_q;
  assign sc_qy     = qy_q;
  assign sc_w      = w_q;
  assign sc_w_avg  = w_avg_q;
  assign out_valid = out_valid_q;
  assign out_f     = best_q;
`ifdef CHAIN_BACKTRACK_EN
  assign out_pred  = pred_q;
`else
  assign out_pred  = '0;
`endif

endmodule
